// File: rtl/databus_axi_writer_pkg.sv
// Shared constants, FSM encoding and helpers for the databus-to-AXI4 write bridge.
package databus_axi_writer_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4KB        = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/databus_axi_writer_axi_burst_split.sv
// Tracks the running byte address and remaining beats of a transfer and sizes the
// next INCR burst so it never exceeds MAX_BURST beats or crosses a 4 KB page.
module databus_axi_writer_axi_burst_split
  import databus_axi_writer_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int LEN_W      = 16,
  parameter int BYTES      = 4,
  parameter int MAX_BURST  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [AXI_ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]      total_i,
  input  logic                  beat_i,
  input  logic                  done_i,
  input  logic [8:0]            done_beats_i,
  output logic [LEN_W-1:0]      remaining_o,
  output logic [AXI_ADDR_W-1:0] next_addr_o,
  output logic [8:0]            next_beats_o
);

  localparam int LOG2B = clog2(BYTES);

  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [12:0]           room;
  logic [8:0]            beats;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = addr_i;
      rem_d  = total_i;
    end else begin
      if (beat_i) rem_d = rem_q - LEN_W'(1);
      if (done_i) addr_d = addr_q + (AXI_ADDR_W'(done_beats_i) << LOG2B);
    end
  end

  // Sizing works on the next-state values so the top can register AW fields on the
  // same edge that loads or advances the address.
  assign room = (13'(AXI_4KB) - {1'b0, addr_d[11:0]}) >> LOG2B;

  always_comb begin
    beats = 9'(MAX_BURST);
    if (room < 13'(MAX_BURST)) beats = room[8:0];
    if (rem_d < LEN_W'(beats)) beats = rem_d[8:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign remaining_o  = rem_q;
  assign next_addr_o  = addr_d;
  assign next_beats_o = beats;

endmodule

// File: rtl/databus_axi_writer.sv
// Databus-slave to AXI4 write-master bridge: one request becomes a series of INCR bursts,
// one outstanding at a time. Optional sticky bresp error flag: DATABUS_AXI_WRITER_ERROR_EN.
module databus_axi_writer
  import databus_axi_writer_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    databus_valid_i,
  output logic                    databus_ready_o,
  input  logic [AXI_ADDR_W-1:0]   databus_addr_i,
  input  logic [LEN_W-1:0]        databus_len_i,
  input  logic [AXI_DATA_W-1:0]   databus_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] databus_wstrb_i,
  output logic                    databus_last_o,
  output logic                    m_axi_awvalid_o,
  input  logic                    m_axi_awready_i,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr_o,
  output logic [7:0]              m_axi_awlen_o,
  output logic [2:0]              m_axi_awsize_o,
  output logic [1:0]              m_axi_awburst_o,
  output logic                    m_axi_wvalid_o,
  input  logic                    m_axi_wready_i,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb_o,
  output logic                    m_axi_wlast_o,
  input  logic                    m_axi_bvalid_i,
  output logic                    m_axi_bready_o,
  input  logic [1:0]              m_axi_bresp_i,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int BYTES = AXI_DATA_W / 8;
  localparam int LOG2B = clog2(BYTES);

  state_e                state_q;
  logic                  awvalid_q, bready_q, busy_q;
  logic [AXI_ADDR_W-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic [8:0]            burst_cnt_q;
  logic [LOG2B-1:0]      tail_q;

  logic                  req_accept, w_beat, b_done, final_beat;
  logic [LEN_W:0]        len_round;
  logic [LEN_W-1:0]      total_beats, split_rem;
  logic [AXI_ADDR_W-1:0] split_addr;
  logic [8:0]            split_beats;
  logic [BYTES-1:0]      tail_mask;
  logic                  unused_bresp;

  assign req_accept  = (state_q == ST_IDLE) && databus_valid_i && (databus_len_i != '0);
  assign w_beat      = (state_q == ST_DATA) && databus_valid_i && m_axi_wready_i;
  assign b_done      = (state_q == ST_RESP) && bready_q && m_axi_bvalid_i;
  assign len_round   = {1'b0, databus_len_i} + (LEN_W + 1)'(BYTES - 1);
  assign total_beats = LEN_W'(len_round >> LOG2B);
  assign final_beat  = (split_rem == LEN_W'(1));

  databus_axi_writer_axi_burst_split #(
    .AXI_ADDR_W (AXI_ADDR_W),
    .LEN_W      (LEN_W),
    .BYTES      (BYTES),
    .MAX_BURST  (MAX_BURST)
  ) u_split (
    .clk          (clk),
    .rst          (rst),
    .load_i       (req_accept),
    .addr_i       (databus_addr_i),
    .total_i      (total_beats),
    .beat_i       (w_beat),
    .done_i       (b_done),
    .done_beats_i ({1'b0, awlen_q} + 9'd1),
    .remaining_o  (split_rem),
    .next_addr_o  (split_addr),
    .next_beats_o (split_beats)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      burst_cnt_q <= '0;
      tail_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_accept) begin
            state_q   <= ST_ADDR;
            busy_q    <= 1'b1;
            tail_q    <= databus_len_i[LOG2B-1:0];
            awvalid_q <= 1'b1;
            awaddr_q  <= split_addr;
            awlen_q   <= 8'(split_beats - 9'd1);
          end
        end
        ST_ADDR: begin
          if (m_axi_awready_i) begin
            awvalid_q   <= 1'b0;
            burst_cnt_q <= {1'b0, awlen_q} + 9'd1;
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_beat) begin
            burst_cnt_q <= burst_cnt_q - 9'd1;
            if (burst_cnt_q == 9'd1) begin
              state_q  <= ST_RESP;
              bready_q <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (b_done) begin
            bready_q <= 1'b0;
            if (split_rem != '0) begin
              state_q   <= ST_ADDR;
              awvalid_q <= 1'b1;
              awaddr_q  <= split_addr;
              awlen_q   <= 8'(split_beats - 9'd1);
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DATABUS_AXI_WRITER_ERROR_EN
  logic error_q;

  // Sticky until the next accepted request so the requester can poll after completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (req_accept) begin
      error_q <= 1'b0;
    end else if (b_done && m_axi_bresp_i[1]) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign unused_bresp = ^m_axi_bresp_i;

  // A zero tail means the last beat is a full word.
  assign tail_mask = (BYTES'(1) << tail_q) - BYTES'(1);

  assign databus_ready_o = (state_q == ST_DATA) && m_axi_wready_i;
  assign databus_last_o  = (state_q == ST_DATA) && final_beat;
  assign m_axi_wvalid_o  = (state_q == ST_DATA) && databus_valid_i;
  assign m_axi_wdata_o   = databus_wdata_i;
  assign m_axi_wstrb_o   = (final_beat && (tail_q != '0)) ? (databus_wstrb_i & tail_mask)
                                                          : databus_wstrb_i;
  assign m_axi_wlast_o   = (state_q == ST_DATA) && (burst_cnt_q == 9'd1);

  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_awaddr_o  = awaddr_q;
  assign m_axi_awlen_o   = awlen_q;
  assign m_axi_awsize_o  = 3'(LOG2B);
  assign m_axi_awburst_o = AXI_BURST_INCR;
  assign m_axi_bready_o  = bready_q;
  assign busy_o          = busy_q;

endmodule

// File: doc/databus_axi_writer.md
Name: databus_axi_writer

Overview:
- Databus-slave to AXI4-write-master bridge placed directly downstream of the VWrite unit's databus port.
- Accepts one byte-length write request (address, length), splits it into AXI4 INCR bursts (max MAX_BURST beats, never crossing a 4 KB boundary) and streams the requester's data beats onto the W channel.
- Retires each burst on its B response.
- One burst outstanding at a time.

Parameters:
- AXI_ADDR_W, 32, address width.
- AXI_DATA_W, 32, data width (32/64/128); BYTES = AXI_DATA_W/8.
- LEN_W, 16, width of the databus byte-length field.
- MAX_BURST, 256, maximum beats per AXI burst (power of two, 1..256).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- databus_valid_i  in  1  request/data valid from requester.
- databus_ready_o  out  1  data beat accepted this cycle.
- databus_addr_i  in  AXI_ADDR_W  start byte address, BYTES-aligned; sampled at request.
- databus_len_i  in  LEN_W  transfer length in bytes; sampled at request.
- databus_wdata_i  in  AXI_DATA_W  beat data.
- databus_wstrb_i  in  AXI_DATA_W/8  beat strobes.
- databus_last_o  out  1  final beat of the whole transfer; qualified by ready.
- m_axi_awvalid_o / awready_i  out / in  1  AW handshake.
- m_axi_awaddr_o  out  AXI_ADDR_W  burst address.
- m_axi_awlen_o  out  8  beats-1.
- m_axi_awsize_o  out  3  log2(BYTES).
- m_axi_awburst_o  out  2  constant 2'b01.
- m_axi_wvalid_o / wready_i  out / in  1  W handshake.
- m_axi_wdata_o  out  AXI_DATA_W  data.
- m_axi_wstrb_o  out  AXI_DATA_W/8  strobes.
- m_axi_wlast_o  out  1  last beat of burst.
- m_axi_bvalid_i / bready_o  in / out  1  B handshake.
- m_axi_bresp_i  in  2  response.
- busy_o  out  1  transfer in progress.
- error_o  out  1  sticky response error (see Optional Feature).

Behaviour:
- Reset: FSM = IDLE. Outputs awvalid, wvalid, bready, databus_ready_o, databus_last_o, busy_o, error_o = 0. Address/counter registers cleared.
- FSM states: IDLE -> ADDR -> DATA -> RESP -> (ADDR or IDLE).
- IDLE:
  - databus_valid_i=1 and databus_len_i!=0: latch addr, compute total beats = ceil(len/BYTES), latch tail bytes = len mod BYTES (0 means full beat), set busy_o, go to ADDR next cycle.
  - len=0: request ignored; stays IDLE, no AXI traffic, no ready.
- ADDR:
  - burst beats = min(remaining, MAX_BURST, (4096 - addr[11:0])/BYTES).
  - awaddr = current addr; awlen = beats-1; awvalid held until awready; then go to DATA.
  - awaddr/awlen are registered and stable while awvalid=1.
- DATA:
  - wvalid = databus_valid_i.
  - databus_ready_o = wready_i (combinational pass-through; zero added latency).
  - wdata = databus_wdata_i.
  - wlast = burst-beat counter at final beat.
  - Each beat: decrement burst and total counters.
  - Final beat of the transfer with tail bytes nonzero: wstrb = databus_wstrb_i AND ((1<<tail)-1); otherwise wstrb = databus_wstrb_i unmodified.
  - databus_last_o = 1 on the final beat of the whole transfer only.
  - After wlast accepted, go to RESP.
- RESP:
  - bready=1 until bvalid.
  - On B: addr += beats*BYTES (wraps modulo 2^AXI_ADDR_W).
  - Remaining total beats != 0 -> ADDR; else -> IDLE, busy_o=0 next cycle.
- databus_valid_i outside DATA is ignored. The requester must drop valid after databus_last_o; a new request is accepted only in IDLE, so the earliest restart is one cycle after the final B.
- Simultaneous awready in the first ADDR cycle: AW completes in one cycle.
- Burst of 1 beat: awlen=0, wlast on the first beat.
- wready low: wvalid stays asserted and data is held by the requester; no beat counted.
- Reset mid-operation: immediate return to IDLE with all valids low; AXI protocol violation is accepted; the system resets the slave together with this block.

Optional Feature:
- Macro DATABUS_AXI_WRITER_ERROR_EN.
- Defined: error_o sets on any B handshake with bresp[1]=1 (SLVERR/DECERR); it clears only when a new request is accepted in IDLE, or on rst. The transfer still runs to completion.
- Undefined: error_o tied 0; bresp ignored.

Decomposition:
- Shared header/package:
  - AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
  - AXI_4KB = 4096.
  - FSM state encodings (IDLE=0, ADDR=1, DATA=2, RESP=3).
  - function clog2 for awsize.
- Sub-module axi_burst_split: holds current address and remaining-beat registers; produces the next burst address/length with the 4 KB and MAX_BURST clamps; advances on a "burst done" strobe.
- The top module holds the FSM and the W-channel strobe/last logic.

Test Plan:
- addr=0x1000, len=16, BYTES=4, always-ready slave -> one AW (addr 0x1000, awlen=3, awsize=2); 4 W beats, wlast on the 4th; databus_last_o on the 4th; busy_o low after B.
- addr=0x0, len=1200, MAX_BURST=256 -> AW1 0x0/awlen 255, AW2 0x400/awlen 43; 300 total ready pulses; one last pulse.
- addr=0x0FF8, len=32 -> AW1 0x0FF8/awlen 1, AW2 0x1000/awlen 5; no 4 KB crossing.
- addr=0x2000, len=6, wstrb_i=0xF -> 2 beats, wstrb 0xF then 0x3; wready toggling 1,0,0,1 stretches the transfer to 4 cycles with no beat duplicated or lost.
- bresp=2'b10 on the first of two bursts -> macro on: error_o=1 from the B cycle+1, second burst still issued, error_o clears on the next request. Macro off: error_o stays 0.
- rst asserted in DATA after 2 of 4 beats -> all outputs 0 and FSM IDLE immediately; a fresh request afterwards runs correctly from awaddr.
